fifo_wr_ptr_full: RTL

Write-domain pointer and full-flag controller for the asynchronous FIFO. It sits directly upstream of the FIFO memory buffer and produces the write address and the full flag that gate memory writes. It also produces the Gray-coded write pointer that the read-domain synchronizer consumes, and it compares against the read pointer already synchronized into the write clock domain. It optionally reports occupancy and almost-full status to the producer.

---
 rtl/fifo_wr_ptr_full.sv | 81 ++++++++
 1 files changed

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer and full-flag logic for the async FIFO: binary/Gray write pointer, registered full, sticky overflow.
// Define FIFO_WR_LEVEL_EN to add registered occupancy (wlevel) and almost-full (walmost_full). ADDR_W must be >= 2.
module fifo_wr_ptr_full #(
    parameter int ADDR_W    = 3,
    parameter int AFULL_THR = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
`ifdef FIFO_WR_LEVEL_EN
    output logic              wovfl,
    output logic [ADDR_W:0]   wlevel,
    output logic              walmost_full
`else
    output logic              wovfl
`endif
);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] full_ptr;
    logic            push;
    logic            wfull_next;

    assign push       = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, push};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer, in Gray form.
    assign full_ptr   = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    assign wfull_next = (wgray_next == full_ptr);

    assign waddr = wbin[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            wovfl <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgray_next;
            wfull <= wfull_next;
            wovfl <= wovfl | (winc & wfull);
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [ADDR_W:0] AFULL_LVL = AFULL_THR[ADDR_W:0];

    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign level_next = wbin_next - rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= AFULL_LVL);
        end
    end
`else
`endif

endmodule
